// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one imem request at a time,
// and holds each fetched word until decode accepts it, applying redirects on accept.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] FETCH = 2'b01;
   localparam logic [1:0] HOLD  = 2'b10;

   logic [1:0]  state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] pc_out_r, pc_out_s;
   logic [31:0] instr_r, instr_s;
   logic [31:0] count_r, count_s;
   logic        req_r, req_s;
   logic        valid_r, valid_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] br_target_s;
   logic [31:0] jmp_target_s;
   logic [31:0] redirect_s;

   assign pc_plus4_s   = pc_out_r + 32'd4;
   assign br_target_s  = pc_plus4_s + {{14{branch_imm[15]}}, branch_imm, 2'b00};
   assign jmp_target_s = {pc_plus4_s[31:28], jump_index, 2'b00};

   // Redirect priority: jump over taken branch over sequential fall-through.
   always_comb begin
      redirect_s = pc_plus4_s;
      if (jump) begin
         redirect_s = jmp_target_s;
      end else if (branch_taken) begin
         redirect_s = br_target_s;
      end else begin
         redirect_s = pc_plus4_s;
      end
   end

   // FSM next-state and datapath updates; req/valid are computed one edge ahead so they leave as flops.
   always_comb begin
      state_s  = state_r;
      pc_s     = pc_r;
      pc_out_s = pc_out_r;
      instr_s  = instr_r;
      count_s  = count_r;
      req_s    = req_r;
      valid_s  = valid_r;
      case (state_r)
         IDLE: begin
            state_s = FETCH;
            req_s   = 1'b1;
            valid_s = 1'b0;
         end
         FETCH: begin
            if (imem_ack) begin
               state_s  = HOLD;
               instr_s  = imem_rdata;
               pc_out_s = pc_r;
               req_s    = 1'b0;
               valid_s  = 1'b1;
            end else begin
               state_s = FETCH;
               req_s   = 1'b1;
               valid_s = 1'b0;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               state_s = FETCH;
               pc_s    = {redirect_s[31:2], 2'b00};
               count_s = count_r + 32'd1;
               req_s   = 1'b1;
               valid_s = 1'b0;
            end else begin
               state_s = HOLD;
               req_s   = 1'b0;
               valid_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
            req_s   = 1'b0;
            valid_s = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any in-flight request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         pc_r     <= RESET_PC;
         pc_out_r <= RESET_PC;
         instr_r  <= 32'd0;
         count_r  <= 32'd0;
         req_r    <= 1'b0;
         valid_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         pc_r     <= pc_s;
         pc_out_r <= pc_out_s;
         instr_r  <= instr_s;
         count_r  <= count_s;
         req_r    <= req_s;
         valid_r  <= valid_s;
      end
   end

   assign imem_req    = req_r;
   assign imem_addr   = pc_r;
   assign instr_valid = valid_r;
   assign instr       = instr_r;
   assign op          = instr_r[31:26];
   assign funct       = instr_r[5:0];
   assign pc_out      = pc_out_r;
   assign pc_plus4    = pc_plus4_s;
   assign fetch_count = count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: inputs driven and outputs
// sampled on the falling edge, expected values written out by hand.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] fetch_count;

   int n_tests;
   int n_fail;
   logic [31:0] exp_count;

   instr_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .op           (op),
      .funct        (funct),
      .pc_out       (pc_out),
      .pc_plus4     (pc_plus4),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_index   (jump_index),
      .fetch_count  (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One full fetch: waits for the request, acks after ack_delay cycles, stalls decode,
   // then accepts with the given redirect inputs.
   task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                           input int ack_delay, input int stall, input logic stall_br,
                           input logic j, input logic b, input logic [15:0] imm,
                           input logic [25:0] jidx);
      int n;
      n = 0;
      while (!imem_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", {31'd0, imem_req}, 32'd1);
      check("imem_addr", imem_addr, exp_addr);
      for (int i = 0; i < ack_delay; i++) begin
         @(negedge clk);
         check("addr_hold", imem_addr, exp_addr);
         check("req_hold", {31'd0, imem_req}, 32'd1);
         check("valid_low", {31'd0, instr_valid}, 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack     = 1'b0;
      imem_rdata   = 32'hDEAD_BEEF;
      branch_taken = stall_br;
      for (int i = 0; i < stall; i++) begin
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_instr", instr, word);
         check("stall_pc_out", pc_out, exp_addr);
         check("stall_no_req", {31'd0, imem_req}, 32'd0);
         @(negedge clk);
      end
      branch_taken = 1'b0;
      check("valid", {31'd0, instr_valid}, 32'd1);
      check("instr", instr, word);
      check("op", {26'd0, op}, {26'd0, word[31:26]});
      check("funct", {26'd0, funct}, {26'd0, word[5:0]});
      check("pc_out", pc_out, exp_addr);
      check("pc_plus4", pc_plus4, exp_addr + 32'd4);
      check("hold_no_req", {31'd0, imem_req}, 32'd0);
      instr_ready  = 1'b1;
      jump         = j;
      branch_taken = b;
      branch_imm   = imm;
      jump_index   = jidx;
      @(negedge clk);
      instr_ready  = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      branch_imm   = 16'h0000;
      jump_index   = 26'd0;
      exp_count    = exp_count + 32'd1;
      check("fetch_count", fetch_count, exp_count);
      check("valid_drop", {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      exp_count    = 32'd0;
      rst          = 1'b1;
      imem_ack     = 1'b0;
      imem_rdata   = 32'd0;
      instr_ready  = 1'b0;
      branch_taken = 1'b0;
      branch_imm   = 16'h0000;
      jump         = 1'b0;
      jump_index   = 26'd0;
      repeat (3) @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_addr", imem_addr, 32'h0000_3000);
      check("rst_instr", instr, 32'd0);
      check("rst_count", fetch_count, 32'd0);
      rst = 1'b0;

      // Zero-wait memory, always-ready decode
      do_fetch(32'h0000_3000, 32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'd0);
      do_fetch(32'h0000_3004, 32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'd0);
      do_fetch(32'h0000_3008, 32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'd0);
      check("count_after_3", fetch_count, 32'd3);

      // Late ack plus decode stall
      do_fetch(32'h0000_300C, 32'h8C21_0004, 3, 4, 1'b0, 1'b0, 1'b0, 16'h0000, 26'd0);

      // Branch backwards, jump back to 0x3010, branch forwards, jump back again
      do_fetch(32'h0000_3010, 32'h1000_FFFC, 0, 0, 1'b0, 1'b0, 1'b1, 16'hFFFC, 26'd0);
      do_fetch(32'h0000_3004, 32'h0800_0C04, 0, 0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h0000C04);
      do_fetch(32'h0000_3010, 32'h1000_0003, 0, 0, 1'b0, 1'b0, 1'b1, 16'h0003, 26'd0);
      do_fetch(32'h0000_3020, 32'h0800_0C04, 0, 0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h0000C04);

      // Jump and branch together: jump wins
      do_fetch(32'h0000_3010, 32'h0800_0C10, 0, 0, 1'b0, 1'b1, 1'b1, 16'h0003, 26'h0000C10);

      // Branch asserted only while stalled must not redirect
      do_fetch(32'h0000_3040, 32'h1000_0040, 1, 2, 1'b1, 1'b0, 1'b0, 16'h0040, 26'd0);

      // Reset while a request is outstanding, then a stray ack in IDLE
      check("pre_rst_req", {31'd0, imem_req}, 32'd1);
      check("pre_rst_addr", imem_addr, 32'h0000_3044);
      rst = 1'b1;
      #1;
      check("async_rst_req", {31'd0, imem_req}, 32'd0);
      check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("async_rst_count", fetch_count, 32'd0);
      check("async_rst_instr", instr, 32'd0);
      check("async_rst_addr", imem_addr, 32'h0000_3000);
      @(negedge clk);
      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      check("post_rst_req", {31'd0, imem_req}, 32'd1);
      check("post_rst_addr", imem_addr, 32'h0000_3000);
      check("stray_ack_valid", {31'd0, instr_valid}, 32'd0);
      check("stray_ack_instr", instr, 32'd0);
      check("post_rst_count", fetch_count, 32'd0);
      exp_count = 32'd0;
      do_fetch(32'h0000_3000, 32'h2108_0001, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'd0);
      check("final_addr", imem_addr, 32'h0000_3004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end that supplies the op/funct fields consumed by the decoder (the producer side of the decode interface).
- Owns the PC and runs a single-outstanding request/acknowledge handshake with the instruction memory.
- Holds each fetched word until decode accepts it with a valid/ready handshake.
- Applies branch/jump redirects reported back by decode/execute. No delay slots.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; word aligned.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; imem_addr valid while high
- imem_addr  out  32  byte address of requested word (= pc)
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored unless imem_req=1
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/op/funct/pc_out valid to decode
- instr_ready  in  1  decode accepts the instruction this cycle
- instr  out  32  buffered instruction word
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- pc_out  out  32  address of buffered instruction
- pc_plus4  out  32  pc_out+4
- branch_taken  in  1  Branch AND ALU zero for the presented instruction
- branch_imm  in  16  branch offset field of the presented instruction
- jump  in  1  jump for the presented instruction
- jump_index  in  26  jump target field
- fetch_count  out  32  number of instructions accepted by decode

Behaviour:
- States: IDLE, FETCH, HOLD. Reset forces IDLE.
- Reset values: pc=RESET_PC, instr=0, fetch_count=0, imem_req=0, instr_valid=0.
- Reset mid-operation abandons any in-flight request. A late imem_ack arriving in IDLE is ignored.
- IDLE -> FETCH unconditionally on the next edge.
- imem_req = (state==FETCH). imem_addr = pc, held stable while imem_req=1.
- FETCH: when imem_ack=1, capture imem_rdata into instr, set pc_out=pc, go to HOLD. Otherwise stay in FETCH with request held.
- HOLD: instr_valid=1. Outputs are stable until accepted. The handshake is accept = instr_valid & instr_ready.
- On accept:
  - next pc = jump target if jump=1;
  - else branch target if branch_taken=1;
  - else pc_out+4.
  - fetch_count increments and the FSM goes to FETCH.
- HOLD with instr_ready=0: stay in HOLD. branch_taken and jump are ignored.
- Branch target = pc_out + 4 + (sign_extend(branch_imm) << 2), computed modulo 2^32.
- Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
- jump and branch_taken both high: jump wins.
- PC arithmetic wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). pc[1:0] is always 00.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- Latency: ack in the same cycle as req gives instr_valid on the next cycle. Peak throughput is one instruction per 2 cycles (FETCH+HOLD).
- One request outstanding at most. imem_req never re-asserts before the current word is accepted.
- op, funct and pc_plus4 are combinational from the instr and pc_out registers.

Test Plan:
1. Reset then zero-wait memory (ack same cycle as req) returning 32'h0000_0020, instr_ready=1 → imem_addr 0x3000, 0x3004, 0x3008 on successive FETCH cycles. op=0, funct=6'h20 while valid. fetch_count=3 after three accepts.
2. Memory acks 3 cycles late, with decode ready held low for 4 cycles in HOLD → imem_addr stable during wait. instr/pc_out stable and instr_valid=1 through the stall. No new imem_req until accept.
3. pc_out=0x3010, branch_taken=1, branch_imm=16'hFFFC at accept → next imem_addr=0x3004. Repeat with branch_imm=16'h0003 → 0x3020.
4. pc_out=0x3010, jump=1, branch_taken=1, jump_index=26'h0000C10 at accept → next imem_addr=0x0000_3040 (jump wins).
5. branch_taken=1 with instr_ready=0 for 2 cycles, then ready with branch_taken=0 → no redirect, next addr=pc_out+4.
6. Assert rst while in FETCH awaiting ack, then deliver a stray ack during IDLE → outputs return to reset values. Stray ack ignored. First post-reset imem_addr=0x3000, fetch_count=0.
